// File: rtl/acq_trigger_sequencer_if.sv
// Control/status bundle between the UART FSM / settings registers (master)
// and the acquisition trigger sequencer (slave).
interface acq_trigger_sequencer_if #(
  parameter int NUM_TRIG = 2,
  parameter int CNT_W    = 16
);
  // Commands and settings
  logic                arm;
  logic                disarm;
  logic                force_trig;
  logic                auto_rearm;
  logic [NUM_TRIG-1:0] trig_in;
  logic [NUM_TRIG-1:0] trig_mask;
  logic [NUM_TRIG-1:0] trig_rising;
  logic [CNT_W-1:0]    record_len;
  logic                clk_locked;
  logic                fifo_full;
  logic                fifo_empty;
  // Status and strobes
  logic                record;
  logic                comp_reset;
  logic                triggered;
  logic [NUM_TRIG-1:0] trig_source;
  logic [2:0]          state;
  logic [CNT_W-1:0]    trig_count;

  modport master (
    output arm, disarm, force_trig, auto_rearm, trig_in, trig_mask,
           trig_rising, record_len, clk_locked, fifo_full, fifo_empty,
    input  record, comp_reset, triggered, trig_source, state, trig_count
  );

  modport slave (
    input  arm, disarm, force_trig, auto_rearm, trig_in, trig_mask,
           trig_rising, record_len, clk_locked, fifo_full, fifo_empty,
    output record, comp_reset, triggered, trig_source, state, trig_count
  );
endinterface

// File: rtl/acq_trigger_sequencer.sv
// Acquisition trigger sequencer: synchronises and edge-detects NUM_TRIG
// trigger sources, pulses the comparator reset on arm, then drives a
// length-bounded record strobe and waits for the FIFOs to drain.
module acq_trigger_sequencer #(
  parameter int NUM_TRIG    = 2,
  parameter int CNT_W       = 16,
  parameter int RST_PULSE   = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                Reset_n,
  acq_trigger_sequencer_if.slave bus
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_COMP = 3'd1,
    ST_ARMED      = 3'd2,
    ST_RECORD     = 3'd3,
    ST_WAIT_DRAIN = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0][NUM_TRIG-1:0] sync_q;
  logic [NUM_TRIG-1:0]                  hist_q;
  logic [NUM_TRIG-1:0]                  sync_now;
  logic [NUM_TRIG-1:0]                  edge_vec;
  logic                                 hit;

  state_e              state_q;
  logic                record_q;
  logic                comp_reset_q;
  logic                triggered_q;
  logic [NUM_TRIG-1:0] trig_source_q;
  logic [CNT_W-1:0]    trig_count_q;
  logic [CNT_W-1:0]    len_cnt_q;
  logic [PW-1:0]       pulse_cnt_q;
  logic [CNT_W-1:0]    len_load;

  // Shift the raw triggers through the synchroniser chain plus one history stage.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_now = sync_q[SYNC_STAGES-1];
  assign edge_vec = bus.trig_mask & ((bus.trig_rising  & sync_now & ~hist_q) |
                                     (~bus.trig_rising & ~sync_now & hist_q));
  assign hit      = (|edge_vec) | bus.force_trig;
  assign len_load = (bus.record_len == '0) ? CNT_W'(1) : bus.record_len;

  // Sequencer FSM with registered strobes; disarm overrides everything.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      record_q      <= 1'b0;
      comp_reset_q  <= 1'b0;
      triggered_q   <= 1'b0;
      trig_source_q <= '0;
      trig_count_q  <= '0;
      len_cnt_q     <= '0;
      pulse_cnt_q   <= '0;
    end else if (bus.disarm) begin
      state_q      <= ST_IDLE;
      record_q     <= 1'b0;
      comp_reset_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.arm && bus.clk_locked) begin
            state_q       <= ST_RESET_COMP;
            comp_reset_q  <= 1'b1;
            pulse_cnt_q   <= PW'(RST_PULSE - 1);
            triggered_q   <= 1'b0;
            trig_source_q <= '0;
          end
        end
        ST_RESET_COMP: begin
          if (!bus.clk_locked) begin
            state_q      <= ST_IDLE;
            comp_reset_q <= 1'b0;
          end else if (pulse_cnt_q == '0) begin
            state_q      <= ST_ARMED;
            comp_reset_q <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - PW'(1);
          end
        end
        ST_ARMED: begin
          if (!bus.clk_locked) begin
            state_q <= ST_IDLE;
          end else if (hit) begin
            state_q       <= ST_RECORD;
            record_q      <= 1'b1;
            len_cnt_q     <= len_load;
            trig_source_q <= edge_vec;
            triggered_q   <= 1'b1;
            if (trig_count_q != '1) trig_count_q <= trig_count_q + CNT_W'(1);
          end
        end
        ST_RECORD: begin
          // The cycle holding count 1 is the last record cycle.
          if (bus.fifo_full || !bus.clk_locked || len_cnt_q <= CNT_W'(1)) begin
            state_q  <= ST_WAIT_DRAIN;
            record_q <= 1'b0;
          end else begin
            len_cnt_q <= len_cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT_DRAIN: begin
          if (bus.fifo_empty) begin
            if (bus.auto_rearm) begin
              state_q       <= ST_RESET_COMP;
              comp_reset_q  <= 1'b1;
              pulse_cnt_q   <= PW'(RST_PULSE - 1);
              triggered_q   <= 1'b0;
              trig_source_q <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.record      = record_q;
  assign bus.comp_reset  = comp_reset_q;
  assign bus.triggered   = triggered_q;
  assign bus.trig_source = trig_source_q;
  assign bus.state       = state_q;
  assign bus.trig_count  = trig_count_q;

endmodule

// File: doc/acq_trigger_sequencer.md
Name: acq_trigger_sequencer

Overview:
- Parametrised successor to the single-comparator trigger/record path.
- Arbitrates NUM_TRIG masked, edge-selectable trigger sources plus a software force-trigger, and pulses the comparator reset.
- Drives a length-bounded record strobe to the data FIFOs, then waits for drain and optionally re-arms automatically.
- Sits between the main UART FSM / settings registers and the DataStorage write strobe.

Parameters:
- NUM_TRIG, 2, number of trigger sources (1..8).
- CNT_W, 16, width of record length and trigger counter.
- RST_PULSE, 4, comparator reset pulse length in clk cycles (>=1).
- SYNC_STAGES, 2, synchroniser depth on trig_in (>=2).

Ports:
- clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse: start arming.
- disarm  in  1  one-cycle pulse: abort to IDLE.
- force_trig  in  1  one-cycle pulse: software trigger.
- auto_rearm  in  1  level: re-arm after drain.
- trig_in  in  NUM_TRIG  asynchronous trigger inputs.
- trig_mask  in  NUM_TRIG  1 = source enabled.
- trig_rising  in  NUM_TRIG  1 = rising edge, 0 = falling edge.
- record_len  in  CNT_W  samples per capture; 0 is treated as 1.
- clk_locked  in  1  ADC clock DCM locked.
- fifo_full  in  1  storage full.
- fifo_empty  in  1  storage drained.
- record  out  1  FIFO write-enable level.
- comp_reset  out  1  comparator reset pulse.
- triggered  out  1  high from trigger until the next arm.
- trig_source  out  NUM_TRIG  latched sources that fired; bit set = fired.
- state  out  3  encoded FSM state.
- trig_count  out  CNT_W  saturating count of accepted triggers.

Behaviour:
- Reset values: all outputs 0; state = IDLE (0); synchronisers cleared.
- trig_in passes through SYNC_STAGES flops plus one history flop.
- edge[i] = mask[i] & (rising[i] ? sync&~hist : ~sync&hist).
- hit = |edge | force_trig.
- States (encoding):
  - IDLE(0): arm & clk_locked -> RESET_COMP; arm while unlocked is ignored.
  - RESET_COMP(1): comp_reset=1 for exactly RST_PULSE cycles; clears triggered and trig_source; then -> ARMED.
  - ARMED(2): on hit -> RECORD next cycle; latch trig_source = edge vector (force alone gives all-zero source); set triggered; trig_count++ saturating at all-ones; load down-counter with max(record_len,1).
  - RECORD(3): record=1 (registered, first high cycle = first cycle in RECORD); counter decrements each cycle; at count 1 -> WAIT_DRAIN. Asserted for exactly max(record_len,1) cycles. fifo_full or loss of clk_locked ends RECORD early -> WAIT_DRAIN the following cycle.
  - WAIT_DRAIN(4): record=0; when fifo_empty: auto_rearm -> RESET_COMP, else -> IDLE.
- Hits outside ARMED are ignored and not counted; hits arriving during RECORD are not queued.
- Precedence: disarm in any state -> IDLE next cycle, record and comp_reset drop at once, triggered keeps its value. disarm beats hit beats arm.
- arm outside IDLE is ignored.
- Losing clk_locked in RESET_COMP or ARMED -> IDLE.
- record_len is sampled only at trigger; changes mid-capture have no effect.
- Asserting Reset_n low at any point returns all outputs to reset values immediately.

Test Plan:
- NUM_TRIG=2, mask=01, rising=01, record_len=5; arm, then rising edge on trig_in[0] -> comp_reset high 4 cycles; triggered set; trig_source=01; record high exactly 5 cycles; state 4; with fifo_empty=1 and auto_rearm=0 -> IDLE; trig_count=1.
- mask=01; edge on trig_in[1] only -> no trigger. Set mask=11, rising[1]=0, falling edge on trig_in[1] -> trig_source=10.
- force_trig with record_len=0 -> record high 1 cycle; trig_source=00.
- auto_rearm=1, record_len=3; hold fifo_empty=0 for 10 cycles then release -> stays in WAIT_DRAIN until release, then comp_reset pulse, back to ARMED; second trigger gives trig_count=2.
- fifo_full raised 2 cycles into a record_len=100 capture -> record drops the next cycle; state 4.
- disarm during RECORD -> IDLE next cycle, record=0. Reset_n pulsed low mid-RECORD -> all outputs 0 asynchronously.
- Saturation: CNT_W=4, 16 triggers -> trig_count stays at 15.
- arm with clk_locked=0 -> stays IDLE.
